ring_johnson_counter: RTL and testbench

Parametrised shift-register counter: a WIDTH-bit one-hot ring counter or a 2·WIDTH-state Johnson (twisted-ring) counter, selected at run time. Supports shifting in either direction, count enable, parallel load, and a registered wrap pulse. Optional illegal-state self-correction. Used as a sequencer and phase generator, replacing the fixed 4-bit hand-wired ring counters.

---
 rtl/rjc_pkg.sv | 20 ++
 rtl/ring_johnson_counter_if.sv | 24 ++
 rtl/rjc_stage.sv | 21 ++
 rtl/ring_johnson_counter.sv | 86 ++++++++
 tb/tb_ring_johnson_counter.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/rjc_pkg.sv
// Shared constants and HOME helper for the ring/Johnson counter.
// Optional build macro: RJC_SELFCORRECT_EN.
package rjc_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;
    localparam int   MAXW         = 64;

    function automatic logic [MAXW-1:0] home(
        input logic mode,
        input int   width
    );
        home = '0;
        if (mode == MODE_RING && width > 0)
            home[0] = 1'b1;
    endfunction

endpackage

// File: rtl/ring_johnson_counter_if.sv
// Control/status bundle of the ring/Johnson counter.
// Optional build macro: RJC_SELFCORRECT_EN.
interface ring_johnson_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             illegal;

    modport master (
        output en, mode, dir, load, load_val,
        input  q, wrap, illegal
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output q, wrap, illegal
    );
endinterface

// File: rtl/rjc_stage.sv
// One counter stage: D flop with sync reset value, load and enable.
// Optional build macro: RJC_SELFCORRECT_EN.
module rjc_stage (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= rst_val;
        else if (load)
            q <= load_val;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/ring_johnson_counter.sv
// Ring / Johnson shift counter with wrap pulse.
// Build macro RJC_SELFCORRECT_EN adds illegal-state correction.
module ring_johnson_counter
    import rjc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    ring_johnson_counter_if.slave bus
);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] home_v;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] d;
    logic             fb_l;
    logic             fb_r;
    logic             bad;
    logic             wrap_q;

    assign home_v = WIDTH'(home(bus.mode, WIDTH));

    always_comb begin
        fb_l = q[WIDTH-1];
        fb_r = q[0];
        if (bus.mode == MODE_JOHNSON) begin
            fb_l = ~q[WIDTH-1];
            fb_r = ~q[0];
        end
        if (bus.dir == DIR_RIGHT)
            shifted = {fb_r, q[WIDTH-1:1]};
        else
            shifted = {q[WIDTH-2:0], fb_l};
    end

`ifdef RJC_SELFCORRECT_EN
    logic [WIDTH-2:0] diff;
    logic             ring_ok;
    logic             john_ok;
    logic             ill_q;

    assign diff    = q[WIDTH-2:0] ^ q[WIDTH-1:1];
    assign ring_ok = ($countones(q) == 1);
    assign john_ok = ($countones(diff) <= 1);
    assign bad     = (bus.mode == MODE_JOHNSON)
                   ? !john_ok : !ring_ok;

    always_ff @(posedge clk) begin
        if (reset || bus.load || !bus.en)
            ill_q <= 1'b0;
        else
            ill_q <= bad;
    end

    assign bus.illegal = ill_q;
`else
    assign bad         = 1'b0;
    assign bus.illegal = 1'b0;
`endif

    assign d = bad ? home_v : shifted;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        rjc_stage u_stage (
            .clk      (clk),
            .reset    (reset),
            .rst_val  (home_v[i]),
            .load     (bus.load),
            .load_val (bus.load_val[i]),
            .en       (bus.en),
            .d        (d[i]),
            .q        (q[i])
        );
    end

    // Pulse describes the q being written on the same edge.
    always_ff @(posedge clk) begin
        if (reset || bus.load || !bus.en)
            wrap_q <= 1'b0;
        else
            wrap_q <= !bad && (shifted == home_v);
    end

    assign bus.q    = q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed bench for ring_johnson_counter (WIDTH=4).
// Expectations follow RJC_SELFCORRECT_EN when it is defined.
module tb_ring_johnson_counter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    ring_johnson_counter_if #(.WIDTH(4)) bus ();

    ring_johnson_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string      tag,
        input logic [3:0] eq,
        input logic       ew,
        input logic       ei
    );
        check({tag, ".q"}, 32'(bus.q), 32'(eq));
        check({tag, ".wrap"}, 32'(bus.wrap), 32'(ew));
        check({tag, ".illegal"}, 32'(bus.illegal), 32'(ei));
    endtask

    logic [3:0] ring_l [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john_l [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                               4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.en = 1'b0;
        bus.mode = 1'b0;
        bus.dir = 1'b0;
        bus.load = 1'b0;
        bus.load_val = 4'b0000;
        cyc();
        chk("rst_ring", 4'b0001, 1'b0, 1'b0);

        reset = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("ring_l%0d", i), ring_l[i], i == 3, 1'b0);
        end

        bus.mode = 1'b1;
        reset = 1'b1;
        cyc();
        chk("rst_john", 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("john_l%0d", i), john_l[i], i == 7, 1'b0);
        end

        bus.mode = 1'b0;
        bus.load = 1'b1;
        bus.load_val = 4'b0100;
        cyc();
        chk("load_0100", 4'b0100, 1'b0, 1'b0);
        bus.load = 1'b0;
        bus.dir = 1'b1;
        cyc();
        chk("ring_r", 4'b0010, 1'b0, 1'b0);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("hold%0d", i), 4'b0010, 1'b0, 1'b0);
        end
        bus.en = 1'b1;
        cyc();
        chk("ring_r_wrap", 4'b0001, 1'b1, 1'b0);

        bus.dir = 1'b0;
        bus.load = 1'b1;
        bus.load_val = 4'b0110;
        cyc();
        chk("load_en", 4'b0110, 1'b0, 1'b0);
        bus.load = 1'b0;
        cyc();
`ifdef RJC_SELFCORRECT_EN
        chk("ring_bad", 4'b0001, 1'b0, 1'b1);
`else
        chk("ring_bad", 4'b1100, 1'b0, 1'b0);
`endif

        bus.mode = 1'b1;
        bus.load = 1'b1;
        bus.load_val = 4'b0101;
        cyc();
        chk("load_0101", 4'b0101, 1'b0, 1'b0);
        bus.load = 1'b0;
        cyc();
`ifdef RJC_SELFCORRECT_EN
        chk("john_bad", 4'b0000, 1'b0, 1'b1);
`else
        chk("john_bad", 4'b1011, 1'b0, 1'b0);
`endif

        bus.mode = 1'b0;
        bus.load = 1'b1;
        reset = 1'b1;
        cyc();
        chk("rst_mid", 4'b0001, 1'b0, 1'b0);
        reset = 1'b0;
        bus.load = 1'b0;

        bus.mode = 1'b1;
        cyc();
        chk("mode_sw", 4'b0011, 1'b0, 1'b0);
        bus.dir = 1'b1;
        cyc();
        chk("john_r0", 4'b0001, 1'b0, 1'b0);
        cyc();
        chk("john_r1", 4'b0000, 1'b1, 1'b0);
        cyc();
        chk("john_r2", 4'b1000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
